// File: rtl/seg7_pkg.sv
// Shared constants, capture FSM state type and the inverse seven-segment decoder
// used by the display loopback reader.
package seg7_pkg;

  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  localparam logic [6:0] BLANK_PATTERN = 7'h7F;

  typedef enum logic [1:0] {StIdle, StTrack, StHold} cap_state_e;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg7_dec_t;

  // Patterns are active-low, bit0 = a ... bit6 = g.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t d;
    d.valid = 1'b1;
    d.blank = 1'b0;
    d.digit = 4'h0;
    case (seg)
      7'h40: d.digit = 4'h0;
      7'h79: d.digit = 4'h1;
      7'h24: d.digit = 4'h2;
      7'h30: d.digit = 4'h3;
      7'h19: d.digit = 4'h4;
      7'h12: d.digit = 4'h5;
      7'h02: d.digit = 4'h6;
      7'h78: d.digit = 4'h7;
      7'h00: d.digit = 4'h8;
      7'h18: d.digit = 4'h9;
      7'h08: d.digit = 4'hA;
      7'h03: d.digit = 4'hB;
      7'h46: d.digit = 4'hC;
      7'h21: d.digit = 4'hD;
      7'h06: d.digit = 4'hE;
      7'h0E: d.digit = 4'hF;
      BLANK_PATTERN: d.blank = 1'b1;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_reader_if.sv
// Display loopback bus: multiplexed segment/strobe inputs and the recovered frame.
interface seg7_reader_if;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        pattern_err;
  logic        stale;

  modport master (
    output seg_n, dig_n,
    input  digits, dp, blank, frame_valid, pattern_err, stale
  );

  modport slave (
    input  seg_n, dig_n,
    output digits, dp, blank, frame_valid, pattern_err, stale
  );
endinterface

// File: rtl/seg7_pos_capture.sv
// Synchronises the segment bus and strobes, waits for a stable strobe/pattern and
// emits a one-cycle accept pulse carrying the position and decoded fields.
module seg7_pos_capture import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seg_n,
  input  logic [3:0] dig_n,
  output logic       accept,
  output logic [1:0] pos,
  output logic [3:0] digit,
  output logic       dp,
  output logic       blank,
  output logic       bad
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntReach = CntW'(STABLE_CYCLES - 1);

  logic [7:0]      seg_s1_q, seg_s2_q, seg_prev_q;
  logic [3:0]      dig_s1_q, dig_s2_q;
  logic [1:0]      pos_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  cap_state_e      state_q, state_d;
  logic            strobe_ok, same, accept_d;
  logic [1:0]      strobe_pos;
  seg7_dec_t       dec;

  always_comb begin
    strobe_ok  = 1'b0;
    strobe_pos = 2'd0;
    unique case (dig_s2_q)
      4'b1110: begin strobe_ok = 1'b1; strobe_pos = 2'd0; end
      4'b1101: begin strobe_ok = 1'b1; strobe_pos = 2'd1; end
      4'b1011: begin strobe_ok = 1'b1; strobe_pos = 2'd2; end
      4'b0111: begin strobe_ok = 1'b1; strobe_pos = 2'd3; end
      default: ;
    endcase
  end

  assign same = (strobe_pos == pos_prev_q) && (seg_s2_q == seg_prev_q);
  assign dec  = seg7_decode(seg_s2_q[6:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q   <= 8'hFF;
      seg_s2_q   <= 8'hFF;
      dig_s1_q   <= 4'hF;
      dig_s2_q   <= 4'hF;
      seg_prev_q <= 8'hFF;
      pos_prev_q <= 2'd0;
      cnt_q      <= '0;
      state_q    <= StIdle;
      accept     <= 1'b0;
      pos        <= 2'd0;
      digit      <= 4'h0;
      dp         <= 1'b0;
      blank      <= 1'b0;
      bad        <= 1'b0;
    end else begin
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      dig_s1_q   <= dig_n;
      dig_s2_q   <= dig_s1_q;
      seg_prev_q <= seg_s2_q;
      pos_prev_q <= strobe_pos;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      accept     <= accept_d;
      if (accept_d) begin
        pos   <= strobe_pos;
        digit <= dec.digit;
        dp    <= ~seg_s2_q[SegDp];
        blank <= dec.blank;
        bad   <= ~dec.valid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!strobe_ok) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StTrack;
          cnt_d   = CntW'(1);
        end
        StTrack, StHold: begin
          if (!same) begin
            state_d = StTrack;
            cnt_d   = CntW'(1);
          end else begin
            if (state_q == StTrack && cnt_q == CntReach) state_d = StHold;
            if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept_d = strobe_ok && same && (state_q == StTrack) && (cnt_q == CntReach);
  end

endmodule

// File: rtl/seg7_reader.sv
// Recovers 4-digit frames from a multiplexed active-low seven-segment display bus
// and flags undecodable patterns and a stalled display.
module seg7_reader import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic          clk,
  input logic          reset_n,
  seg7_reader_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT_CYCLES);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic          acc, acc_dp, acc_blank, acc_bad;
  logic [1:0]    acc_pos;
  logic [3:0]    acc_digit;
  logic [15:0]   sh_digit_q, sh_digit_d;
  logic [3:0]    sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_bad_q, sh_bad_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   digits_q;
  logic [3:0]    dp_q, blank_q;
  logic          frame_valid_q, pattern_err_q, frame_done;
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  seg7_pos_capture #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_capture (
    .clk    (clk),
    .reset_n(rst_n),
    .seg_n  (bus.seg_n),
    .dig_n  (bus.dig_n),
    .accept (acc),
    .pos    (acc_pos),
    .digit  (acc_digit),
    .dp     (acc_dp),
    .blank  (acc_blank),
    .bad    (acc_bad)
  );

  assign frame_done = (mask_q == 4'hF);

  // An accept landing with frame completion starts the next frame.
  always_comb begin
    sh_digit_d = sh_digit_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    mask_d     = mask_q;
    if (frame_done) begin
      mask_d   = 4'h0;
      sh_bad_d = 4'h0;
    end
    if (acc) begin
      sh_digit_d[{acc_pos, 2'b00} +: 4] = acc_digit;
      sh_dp_d[acc_pos]    = acc_dp;
      sh_blank_d[acc_pos] = acc_blank;
      sh_bad_d[acc_pos]   = acc_bad;
      mask_d[acc_pos]     = 1'b1;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (frame_done)          tcnt_d = '0;
    else if (tcnt_q != TMax) tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digit_q    <= 16'h0;
      sh_dp_q       <= 4'h0;
      sh_blank_q    <= 4'h0;
      sh_bad_q      <= 4'h0;
      mask_q        <= 4'h0;
      digits_q      <= 16'h0;
      dp_q          <= 4'h0;
      blank_q       <= 4'hF;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      sh_digit_q    <= sh_digit_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_bad_q      <= sh_bad_d;
      mask_q        <= mask_d;
      tcnt_q        <= tcnt_d;
      frame_valid_q <= frame_done;
      if (frame_done) begin
        digits_q      <= sh_digit_q;
        dp_q          <= sh_dp_q;
        blank_q       <= sh_blank_q;
        pattern_err_q <= |sh_bad_q;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.stale       = (tcnt_q == TMax);

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: scans digit patterns onto the bus and checks frames.
module tb_seg7_reader;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   fv_count = 0;
  int   fv0;
  int   n;
  logic seen;

  always #5 clk = ~clk;

  seg7_reader_if bus ();

  seg7_reader #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input int p, input logic [7:0] s, input int cyc);
    bus.dig_n = ~(4'b0001 << p);
    bus.seg_n = s;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    bus.dig_n = 4'hF;
    bus.seg_n = 8'hFF;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    show(0, s0, 8);
    show(1, s1, 8);
    show(2, s2, 8);
    show(3, s3, 8);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.dig_n = 4'hF;
    bus.seg_n = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_dp", 32'(bus.dp), 32'h0);
    check("rst_blank", 32'(bus.blank), 32'hF);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_err", 32'(bus.pattern_err), 32'h0);
    check("rst_stale", 32'(bus.stale), 32'h0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1234, no decimal points
    fv0 = fv_count;
    scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    idle(6);
    check("f1_count", 32'(fv_count), 32'(fv0 + 1));
    check("f1_digits", 32'(bus.digits), 32'h1234);
    check("f1_dp", 32'(bus.dp), 32'h0);
    check("f1_blank", 32'(bus.blank), 32'h0);
    check("f1_err", 32'(bus.pattern_err), 32'h0);

    // position 2 blank
    fv0 = fv_count;
    scan(8'hC0, 8'hC0, 8'hFF, 8'hC0);
    idle(6);
    check("f2_count", 32'(fv_count), 32'(fv0 + 1));
    check("f2_digits", 32'(bus.digits), 32'h0);
    check("f2_blank", 32'(bus.blank), 32'h4);
    check("f2_err", 32'(bus.pattern_err), 32'h0);

    // invalid pattern on position 0, then a clean frame with dp on position 1
    fv0 = fv_count;
    scan(8'hAA, 8'hC0, 8'hC0, 8'hC0);
    idle(6);
    check("f3_count", 32'(fv_count), 32'(fv0 + 1));
    check("f3_err", 32'(bus.pattern_err), 32'h1);
    check("f3_digits", 32'(bus.digits), 32'h0);
    check("f3_blank", 32'(bus.blank), 32'h0);
    scan(8'h99, 8'h30, 8'hA4, 8'hF9);
    idle(6);
    check("f4_count", 32'(fv_count), 32'(fv0 + 2));
    check("f4_err", 32'(bus.pattern_err), 32'h0);
    check("f4_dp", 32'(bus.dp), 32'h2);
    check("f4_digits", 32'(bus.digits), 32'h1234);

    // glitching pattern and double strobe must not capture position 0
    fv0 = fv_count;
    for (int i = 0; i < 10; i++) show(0, (i % 2 == 0) ? 8'hC0 : 8'hF9, 3);
    bus.dig_n = 4'b0011;
    bus.seg_n = 8'hC0;
    repeat (10) @(posedge clk);
    #1;
    show(1, 8'hB0, 8);
    show(2, 8'hA4, 8);
    show(3, 8'hF9, 8);
    idle(6);
    check("glitch_nofv", 32'(fv_count), 32'(fv0));
    show(0, 8'h99, 8);
    idle(6);
    check("glitch_fv", 32'(fv_count), 32'(fv0 + 1));
    check("glitch_digits", 32'(bus.digits), 32'h1234);

    // stale after 50 idle cycles, cleared by the next frame
    show(0, 8'h99, 8);
    show(1, 8'hB0, 8);
    show(2, 8'hA4, 8);
    bus.dig_n = 4'b0111;
    bus.seg_n = 8'hF9;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1) seen = 1'b1;
    end
    check("stale_frame_seen", 32'(seen), 32'h1);
    bus.dig_n = 4'hF;
    bus.seg_n = 8'hFF;
    check("stale_low_at_fv", 32'(bus.stale), 32'h0);
    n = 0;
    while (n < 200 && bus.stale !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("stale_cycles", 32'(n), 32'd50);
    @(posedge clk);
    #1;
    check("stale_held", 32'(bus.stale), 32'h1);
    fv0 = fv_count;
    scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    idle(6);
    check("stale_clear_fv", 32'(fv_count), 32'(fv0 + 1));
    check("stale_clear", 32'(bus.stale), 32'h0);

    // reset after three positions discards the partial frame
    show(0, 8'hC0, 8);
    show(1, 8'hC0, 8);
    show(2, 8'hC0, 8);
    reset_n   = 1'b0;
    bus.dig_n = 4'hF;
    bus.seg_n = 8'hFF;
    #2;
    check("mid_rst_digits", 32'(bus.digits), 32'h0);
    check("mid_rst_blank", 32'(bus.blank), 32'hF);
    check("mid_rst_dp", 32'(bus.dp), 32'h0);
    check("mid_rst_stale", 32'(bus.stale), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fv0 = fv_count;
    show(3, 8'hF9, 8);
    idle(6);
    check("post_rst_nofv", 32'(fv_count), 32'(fv0));
    check("post_rst_blank", 32'(bus.blank), 32'hF);
    show(0, 8'h99, 8);
    show(1, 8'hB0, 8);
    show(2, 8'hA4, 8);
    idle(6);
    check("post_rst_fv", 32'(fv_count), 32'(fv0 + 1));
    check("post_rst_digits", 32'(bus.digits), 32'h1234);
    check("post_rst_blank2", 32'(bus.blank), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Inverse of the team's hex-to-seven-segment encoder. Samples a time-multiplexed, active-low 8-bit segment bus plus 4 active-low digit strobes, and recovers the 4-bit digit value and decimal point for each of 4 positions. When all 4 positions have been captured, it publishes a 16-bit frame. It sits on the display loopback path so the ADC display chain can be checked in hardware, comparing displayed digits against the bin2bcd output.

## Interface

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a position is accepted (≥2)
- TIMEOUT_CYCLES, 100000: cycles without a completed frame before `stale` asserts

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- seg_n  in  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp; asynchronous to clk
- dig_n  in  4  digit strobes, active-low, expected one-hot-low; bit i = position i; asynchronous
- digits  out  16  captured digits, position i in [4i+3:4i]
- dp  out  4  captured decimal points, active-high
- blank  out  4  position i displayed all segments off
- frame_valid  out  1  one-cycle pulse when digits/dp/blank update
- pattern_err  out  1  sticky: unrecognised segment pattern accepted; cleared by next clean frame
- stale  out  1  no frame completed within TIMEOUT_CYCLES

## Operation

- seg_n and dig_n each pass through a 2-flop synchroniser. All logic below uses the synchronised values.
- Valid strobe cycle: exactly one dig_n bit low. Zero or multiple low bits reset the stability counter; no capture.
- Stability counter:
  - Increments while the strobe position and seg_n are unchanged from the previous cycle.
  - Reloads to 1 on any change.
  - Saturates at STABLE_CYCLES.
  - On the cycle it reaches STABLE_CYCLES, the position is accepted once; no re-accept until the strobe or pattern changes.
- Decode on accept: seg_n[6:0] maps to a digit via the inverse table (hex, active-low):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F → blank, digit 0
  - Any other pattern → digit 0, error flagged for the frame
- dp on accept: dp = ~seg_n[7].
- Accepted position is written to a shadow register, and its bit is set in a 4-bit capture mask. Re-capturing a position before the frame completes overwrites the shadow entry.
- Frame completion, on mask == 4'hF:
  - Shadow copies to digits/dp/blank.
  - frame_valid pulses.
  - pattern_err is set if any shadow entry was invalid, cleared otherwise.
  - Mask and frame-error accumulator clear.
  - Timeout counter reloads and stale clears.
- Timeout counter:
  - Increments every cycle, saturating.
  - stale = 1 when it reaches TIMEOUT_CYCLES; stays high until the next frame_valid.
- Capture FSM states:
  - IDLE: waiting for a valid strobe.
  - TRACK: counting stability.
  - HOLD: accepted; waiting for a change.
  - Transitions: IDLE→TRACK on a valid strobe. TRACK→HOLD on accept. TRACK/HOLD→TRACK on a strobe or pattern change. Any state→IDLE on an invalid strobe cycle.

## Timing

- Reset (async assert, sync release) values:
  - digits = 0, dp = 0, blank = 4'hF, frame_valid = 0, pattern_err = 0, stale = 0
  - mask = 0, counters = 0, FSM = IDLE
- Input latency: 2 cycles of synchroniser.
- Accept occurs STABLE_CYCLES cycles after the first synchronised sample of a new strobe/pattern.
- Shadow and mask update 1 cycle after accept.
- frame_valid and outputs update 1 cycle after the mask reaches 4'hF.
- Pin-to-frame worst case for the last position: 2 + STABLE_CYCLES + 2 cycles.
- Acceptance of one position in the same cycle as frame completion: it belongs to the next frame; the mask becomes the single new bit.
- Reset mid-frame: the partial frame is discarded; outputs return to reset values immediately.

## Structure

- Package `seg7_pkg`:
  - segment bit-index constants
  - BLANK_PATTERN constant
  - capture FSM state enum
  - function `seg7_decode(input [6:0]) → {valid, blank, digit[3:0]}`
- Sub-module `seg7_pos_capture`: synchroniser, stability counter, FSM. Emits an accept pulse with position index and decoded fields. The top level holds the shadow registers, mask, frame logic and timeout.

## Test plan

- Scan 4 positions with patterns 19, 30, 24, 79 (dp off), each held for 8 cycles → frame_valid once; digits=16'h1234, dp=0, blank=0, pattern_err=0.
- Position 2 shows 7F, the others show 40 → digits=16'h0000, blank=4'b0100.
- Position 0 shows 2A (invalid) → frame completes with pattern_err=1. The following clean frame → pattern_err=0.
- Pattern glitches every 3 cycles with STABLE_CYCLES=4 → no accept, no frame_valid. dig_n=4'b0011 (two strobes low) → no capture.
- Freeze dig_n high with TIMEOUT_CYCLES=50 → stale rises on cycle 50 and clears on the next frame_valid.
- Assert reset_n low after 3 positions are captured, then resume scanning → no frame_valid until all 4 positions are recaptured; outputs at reset values in between.
